// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multicycle RISC-V control unit
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'b0000,
        S_DECODE = 4'b0001,
        S_EXEC   = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB     = 4'b0100,
        S_FAULT  = 4'b1111
    } estado_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IALU) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BR);
    endfunction

    // Only beq/bne are supported; every other funct3 falls through as not taken.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        return ((f3 == F3_BEQ) && zero) || ((f3 == F3_BNE) && !zero);
    endfunction

endpackage

// File: rtl/mem_wdog.sv
// rtl/mem_wdog.sv - counts consecutive unacknowledged memory request cycles
module mem_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;

    // Fires during the TIMEOUT-th waiting cycle so the FSM lands in FAULT
    // exactly TIMEOUT cycles after the request first rose.
    always_comb begin
        waiting = req && !ack;
        cnt_d   = waiting ? cnt_q + CW'(1) : '0;
        expired = waiting && (cnt_q == LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multicycle RISC-V control FSM with fault and retire tracking
module unidade_controle
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ack,
    output logic [3:0]       estado,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count
);

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             wdog_expired;
    logic             retire;
    logic             is_lw;

    mem_wdog #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (mem_req),
        .ack     (mem_ack),
        .expired (wdog_expired)
    );

    always_comb begin
        estado_d      = estado_q;
        instr_count_d = instr_count_q;
        error_d       = error_q;
        err_code_d    = err_code_q;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        alu_src       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_op        = ALU_ADD;
        is_lw         = (opcode == OP_LW);

        unique case (estado_q)
            S_FETCH: begin
                if (run) begin
                    mem_req  = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ack) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        estado_d = S_DECODE;
                    end else if (wdog_expired) begin
                        estado_d   = S_FAULT;
                        error_d    = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
            end

            S_DECODE: begin
                if (is_legal_op(opcode)) begin
                    estado_d = S_EXEC;
                end else begin
                    estado_d   = S_FAULT;
                    error_d    = 1'b1;
                    err_code_d = ERR_ILLEGAL;
                end
            end

            S_EXEC: begin
                unique case (opcode)
                    OP_R: begin
                        alu_op   = ALU_FUNCT;
                        estado_d = S_WB;
                    end
                    OP_IALU: begin
                        alu_op   = ALU_FUNCT;
                        alu_src  = 1'b1;
                        estado_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_op   = ALU_ADD;
                        alu_src  = 1'b1;
                        estado_d = S_MEM;
                    end
                    OP_BR: begin
                        alu_op   = ALU_SUB;
                        pc_write = branch_taken(funct3, zero);
                        pc_src   = branch_taken(funct3, zero);
                        estado_d = S_FETCH;
                        retire   = 1'b1;
                    end
                    // IR is held after DECODE, so this arm only guards a glitching opcode.
                    default: begin
                        estado_d = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                mem_req   = 1'b1;
                mem_read  = is_lw;
                mem_write = !is_lw;
                if (mem_ack) begin
                    if (is_lw) begin
                        estado_d = S_WB;
                    end else begin
                        estado_d = S_FETCH;
                        retire   = 1'b1;
                    end
                end else if (wdog_expired) begin
                    estado_d   = S_FAULT;
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_lw;
                estado_d   = S_FETCH;
                retire     = 1'b1;
            end

            S_FAULT: begin
                error_d = 1'b1;
            end

            default: begin
                estado_d = S_FAULT;
                error_d  = 1'b1;
            end
        endcase

        if (retire) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q      <= S_FETCH;
            instr_count_q <= '0;
            error_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            estado_q      <= estado_d;
            instr_count_q <= instr_count_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
        end
    end

    assign estado      = estado_q;
    assign instr_count = instr_count_q;
    assign error       = error_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - randomized instruction traces checked against a stage-level model
module tb_unidade_controle;

    localparam int TO = 16;
    localparam int CW = 4;

    logic          clk, rst_n, run, zero, mem_ack;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [3:0]    estado;
    logic          mem_req, mem_read, mem_write, ir_write, pc_write, pc_src;
    logic          alu_src, reg_write, mem_to_reg, error;
    logic [1:0]    alu_op, err_code;
    logic [CW-1:0] instr_count;

    unidade_controle #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
        .zero(zero), .mem_ack(mem_ack), .estado(estado), .mem_req(mem_req),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .error(error), .err_code(err_code), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] I_R = 7'h33, I_I = 7'h13, I_LW = 7'h03, I_SW = 7'h23, I_BR = 7'h63;
    localparam logic [3:0] F = 4'd0, D = 4'd1, E = 4'd2, M = 4'd3, W = 4'd4, X = 4'd15;
    // Strobe vector: {req, read, write, ir, pcw, pcsrc, alusrc, regw, m2r, alu_op[1:0]}
    localparam logic [10:0] REQ = 11'h400, RD = 11'h200, WR = 11'h100, IRW = 11'h080;
    localparam logic [10:0] PCW = 11'h040, PCS = 11'h020, ASRC = 11'h010, RW = 11'h008;
    localparam logic [10:0] M2R = 11'h004, A_ADD = 11'h000, A_SUB = 11'h001, A_FN = 11'h002;

    typedef struct {
        logic       run, ack, z;
        logic [6:0] op;
        logic [2:0] f3, err;
        logic [3:0] st, cnt;
        logic [10:0] strb;
    } cyc_t;

    cyc_t q[$];
    int   n_cmp, n_bad, model_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic r, input logic a, input logic [6:0] op, input logic [2:0] f3,
                       input logic z, input logic [3:0] st, input logic [10:0] strb,
                       input logic [2:0] err);
        cyc_t c;
        c.run = r; c.ack = a; c.op = op; c.f3 = f3; c.z = z;
        c.st = st; c.strb = strb; c.err = err; c.cnt = 4'(model_cnt);
        q.push_back(c);
    endtask

    // Expected per-cycle behaviour of one legal instruction, stage by stage.
    task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int fd, input int md);
        logic taken;
        for (int i = 0; i < fd; i++) add(1, 0, 7'($urandom), 3'($urandom), rb(), F, REQ | RD, 0);
        add(1, 1, 7'($urandom), 3'($urandom), rb(), F, REQ | RD | IRW | PCW, 0);
        add(rb(), rb(), op, 3'($urandom), rb(), D, 0, 0);
        case (op)
            I_R: begin
                add(rb(), rb(), op, 3'($urandom), rb(), E, A_FN, 0);
                add(rb(), rb(), op, 3'($urandom), rb(), W, RW, 0);
            end
            I_I: begin
                add(rb(), rb(), op, 3'($urandom), rb(), E, A_FN | ASRC, 0);
                add(rb(), rb(), op, 3'($urandom), rb(), W, RW, 0);
            end
            I_LW, I_SW: begin
                add(rb(), rb(), op, 3'($urandom), rb(), E, A_ADD | ASRC, 0);
                for (int i = 0; i <= md; i++)
                    add(rb(), (i == md), op, 3'($urandom), rb(), M,
                        REQ | ((op == I_LW) ? RD : WR), 0);
                if (op == I_LW) add(rb(), rb(), op, 3'($urandom), rb(), W, RW | M2R, 0);
            end
            default: begin
                taken = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
                add(rb(), rb(), op, f3, z, E, A_SUB | (taken ? (PCW | PCS) : 11'h0), 0);
            end
        endcase
        model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    task automatic play(input int n);
        cyc_t c;
        int   k;
        k = 0;
        while (q.size() > 0 && k < n) begin
            c = q.pop_front();
            k++;
            @(posedge clk);
            #1;
            run = c.run; mem_ack = c.ack; opcode = c.op; funct3 = c.f3; zero = c.z;
            @(negedge clk);
            check("estado", 32'(estado), 32'(c.st));
            check("strobes", 32'({mem_req, mem_read, mem_write, ir_write, pc_write, pc_src,
                                  alu_src, reg_write, mem_to_reg, alu_op}), 32'(c.strb));
            check("instr_count", 32'(instr_count), 32'(c.cnt));
            check("err", 32'({error, err_code}), 32'(c.err));
        end
    endtask

    task automatic reset_dut();
        run = 0; mem_ack = 0;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        q.delete();
        model_cnt = 0;
    endtask

    logic [6:0] legal_ops[5];
    logic [6:0] bad_op;
    int         k;

    initial begin
        #500000;
        $display("FAIL watchdog no finish by t=%0t", $time);
        $fatal(1);
    end

    initial begin
        legal_ops = '{I_R, I_I, I_LW, I_SW, I_BR};
        n_cmp = 0; n_bad = 0; model_cnt = 0;
        rst_n = 1; run = 0; mem_ack = 0; opcode = 0; funct3 = 0; zero = 0;
        #3 rst_n = 0;
        #1;
        check("rst_estado", 32'(estado), 0);
        check("rst_count", 32'(instr_count), 0);
        check("rst_err", 32'({error, err_code}), 0);
        check("rst_strobes", 32'({mem_req, mem_read, mem_write, ir_write, pc_write, reg_write}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        gen_instr(I_R, 3'd0, 0, 0, 0);
        gen_instr(I_LW, 3'd2, 0, 3, 3);
        gen_instr(I_BR, 3'd0, 1, 0, 0);
        gen_instr(I_BR, 3'd1, 1, 0, 0);
        gen_instr(I_SW, 3'd2, 0, TO - 1, TO - 1);
        play(1 << 30);

        for (int i = 0; i < 40; i++) begin
            for (int j = $urandom_range(0, 2); j > 0; j--)
                add(0, rb(), 7'($urandom), 3'($urandom), rb(), F, 0, 0);
            gen_instr(legal_ops[$urandom_range(0, 4)], 3'($urandom_range(0, 3)), rb(),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            play(1 << 30);
        end

        gen_instr(I_SW, 3'd2, 0, 0, 5);
        play(5);
        check("sw_mem_write", 32'(mem_write), 1);
        #2 rst_n = 0;
        #1;
        check("midrst_estado", 32'(estado), 0);
        check("midrst_mem_write", 32'(mem_write), 0);
        check("midrst_count", 32'(instr_count), 0);
        run = 0;
        @(negedge clk);
        rst_n = 1;
        q.delete();
        model_cnt = 0;
        gen_instr(I_I, 3'd0, 0, 1, 0);
        play(1 << 30);

        reset_dut();
        run = 1; mem_ack = 0;
        k = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            @(posedge clk);
            #1;
            if (estado == X) begin k = i; break; end
        end
        check("timeout_cycles", 32'(k), 32'(TO));
        check("timeout_err", 32'({error, err_code}), 32'(3'b110));

        reset_dut();
        add(1, 1, 7'($urandom), 3'($urandom), rb(), F, REQ | RD | IRW | PCW, 0);
        add(1, rb(), 7'h7F, 3'($urandom), rb(), D, 0, 0);
        for (int i = 0; i < 20; i++) add(1, rb(), 7'($urandom), 3'($urandom), rb(), X, 0, 3'b101);
        play(1 << 30);

        reset_dut();
        do bad_op = 7'($urandom); while (bad_op inside {I_R, I_I, I_LW, I_SW, I_BR});
        add(1, 0, 7'($urandom), 3'($urandom), rb(), F, REQ | RD, 0);
        add(1, 1, 7'($urandom), 3'($urandom), rb(), F, REQ | RD | IRW | PCW, 0);
        add(rb(), rb(), bad_op, 3'($urandom), rb(), D, 0, 0);
        for (int i = 0; i < 4; i++) add(1, rb(), 7'($urandom), 3'($urandom), rb(), X, 0, 3'b101);
        play(1 << 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max cycles waiting for mem_ack before fault.
REQ-002 SHALL have parameter CNT_W, default 32, width of instr_count.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port run  input  1  permits a new instruction fetch.
REQ-006 SHALL have port opcode  input  7  IR[6:0], valid from the cycle after ir_write.
REQ-007 SHALL have port funct3  input  3  IR[14:12], branch condition select.
REQ-008 SHALL have port zero  input  1  ALU zero flag, valid in EXEC.
REQ-009 SHALL have port mem_ack  input  1  memory completes the current request this cycle.
REQ-010 SHALL have port estado  output  4  current state, fed to the decode and datapath stages.
REQ-011 SHALL have ports mem_req, mem_read, mem_write, ir_write, pc_write, pc_src, alu_src, reg_write, mem_to_reg  output  1 each  datapath strobes and selects.
REQ-012 SHALL have port alu_op  output  2  00 add, 01 sub/compare, 10 decode by funct.
REQ-013 SHALL have ports error  output  1  sticky fault; err_code  output  2  01 illegal opcode, 10 memory timeout.
REQ-014 SHALL have port instr_count  output  CNT_W  retired-instruction count.

Function
REQ-015 SHALL encode states FETCH=0000, DECODE=0001, EXEC=0010, MEM=0011, WB=0100, FAULT=1111; no other state is ever reached.
REQ-016 SHALL hold strobes at 0 in any state or condition not listed below.
REQ-017 FETCH: when run=1, drive mem_req=1, mem_read=1; if mem_ack=1 the same cycle, also drive ir_write=1, pc_write=1, pc_src=0 and go to DECODE; when run=0, drive no request and stay.
REQ-018 DECODE: one cycle; opcode 0110011 (R), 0010011 (I-ALU), 0000011 (lw), 0100011 (sw) or 1100011 (branch) go to EXEC; any other opcode goes to FAULT with err_code=01.
REQ-019 EXEC: R sets alu_op=10 and goes to WB; I-ALU sets alu_op=10, alu_src=1 and goes to WB; lw/sw set alu_op=00, alu_src=1 and go to MEM; branch sets alu_op=01 and goes to FETCH.
REQ-020 EXEC branch: pc_write=1, pc_src=1 when funct3=000 with zero=1 (beq) or funct3=001 with zero=0 (bne); any other funct3 is treated as not taken.
REQ-021 MEM: drive mem_req=1 with mem_read=1 (lw) or mem_write=1 (sw) until mem_ack; on ack lw goes to WB and sw goes to FETCH.
REQ-022 WB: one cycle, reg_write=1, mem_to_reg=1 only for lw; then go to FETCH.
REQ-023 SHALL count consecutive mem_req cycles without mem_ack; when the count reaches MEM_TIMEOUT, go to FAULT with err_code=10; the count clears on ack or on leaving FETCH/MEM.
REQ-024 FAULT: all strobes 0, error=1, err_code held; SHALL stay until reset.
REQ-025 SHALL increment instr_count by 1 on the transition to FETCH from WB, EXEC (branch) or MEM (sw); wraps modulo 2^CNT_W.
REQ-026 SHALL let run=0 mid-instruction not abort; the instruction completes and the block idles in FETCH.
REQ-027 estado and counters are registered; strobes are combinational from state, opcode, zero and mem_ack.

Reset
REQ-028 SHALL, while rst_n=0 regardless of clk, set estado=FETCH, instr_count=0, error=0, err_code=00, timeout count=0, and thereby all strobes=0 when run=0.
REQ-029 SHALL treat reset asserted mid-instruction as an abort; no pending memory request persists.

Structure
REQ-030 SHALL place state encodings, the opcode constants, alu_op codes and err_code values in shared package riscv_ctrl_pkg.
REQ-031 SHALL implement the memory timeout counter as sub-module mem_wdog (inputs clk, rst_n, req, ack; output expired).

Verification
REQ-032 R-type add (0110011), ack on first request -> estado 0000,0001,0010,0100,0000; reg_write=1 in WB only; instr_count 0->1.
REQ-033 lw with mem_ack delayed 3 cycles in both FETCH and MEM -> mem_req held 4 cycles each; mem_to_reg=1 in WB; total 11 cycles.
REQ-034 beq with zero=1, then bne with zero=1 -> first sets pc_write=1, pc_src=1 in EXEC; second sets pc_write=0; count +2.
REQ-035 opcode 1111111 -> FAULT after DECODE, error=1, err_code=01, no strobes for 20 further cycles even with run=1.
REQ-036 mem_ack never returned -> FAULT exactly MEM_TIMEOUT cycles after mem_req rises, err_code=10.
REQ-037 rst_n pulsed low during MEM of sw -> estado=0000 immediately, mem_write=0, instr_count=0.
